// File: rtl/heart_rate_meter.sv
// heart_rate_meter: counts synchronised beat_in rising edges over WINDOW_TICKS timebase ticks.
// Optional refractory lockout on counted beats is built only when HR_LOCKOUT_EN is defined.
module heart_rate_meter #(
    parameter int unsigned WINDOW_TICKS = 12,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned SYNC_STAGES  = 2
`ifdef HR_LOCKOUT_EN
    ,
    parameter int unsigned LOCKOUT_CYC  = 200
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             beat_in,
    input  logic             enable,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    output logic             rate_ovf,
    output logic             busy
);

    localparam int unsigned TCNT_W = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(WINDOW_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURE,
        REPORT
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   beat_edge;
    logic                   cnt_edge;
    logic [CNT_W-1:0]       acc_q, acc_d, acc_inc;
    logic [CNT_W-1:0]       rate_q, rate_d;
    logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
    logic                   wovf_q, wovf_d;
    logic                   ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], beat_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign beat_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

`ifdef HR_LOCKOUT_EN
    localparam int unsigned LK_W = (LOCKOUT_CYC > 0) ? $clog2(LOCKOUT_CYC + 1) : 1;

    logic [LK_W-1:0] lock_q, lock_d;

    // Lockout runs regardless of FSM state; an edge arriving as the counter reaches zero is accepted.
    assign cnt_edge = beat_edge && (lock_q == '0);

    always_comb begin
        lock_d = lock_q;
        if (cnt_edge) begin
            lock_d = LK_W'(LOCKOUT_CYC);
        end else if (lock_q != '0) begin
            lock_d = lock_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= '0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    assign cnt_edge = beat_edge;
`endif

    assign acc_inc = (acc_q == '1) ? acc_q : acc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tcnt_d  = tcnt_q;
        wovf_d  = wovf_q;
        rate_d  = rate_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    acc_d   = '0;
                    tcnt_d  = '0;
                    wovf_d  = 1'b0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    if (cnt_edge) begin
                        acc_d  = acc_inc;
                        wovf_d = wovf_q | (acc_q == '1);
                    end
                    // Closing tick publishes acc_d so an edge on this same cycle is included.
                    if (tick) begin
                        if (tcnt_q == TCNT_LAST) begin
                            rate_d  = acc_d;
                            ovf_d   = wovf_d;
                            state_d = REPORT;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end
                end
            end
            REPORT: begin
                tcnt_d  = '0;
                wovf_d  = 1'b0;
                acc_d   = (enable && cnt_edge) ? CNT_W'(1) : '0;
                state_d = enable ? MEASURE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            tcnt_q  <= '0;
            wovf_q  <= 1'b0;
            rate_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tcnt_q  <= tcnt_d;
            wovf_q  <= wovf_d;
            rate_q  <= rate_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rate       = rate_q;
    assign rate_ovf   = ovf_q;
    assign rate_valid = (state_q == REPORT);
    assign busy       = (state_q == ARMED) || (state_q == MEASURE);

endmodule

// File: tb/tb_heart_rate_meter.sv
// Testbench for heart_rate_meter: directed windows plus randomized stimulus against a window-level model.
// Builds with or without HR_LOCKOUT_EN.
module tb_heart_rate_meter;

    localparam int W      = 4;
    localparam int CW     = 4;
    localparam int SS     = 2;
    localparam int LK     = 10;
    localparam int PERIOD = 20;
    localparam int MAXC   = (1 << CW) - 1;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          tick    = 1'b0;
    logic          beat_in = 1'b0;
    logic          enable  = 1'b0;
    logic [CW-1:0] rate;
    logic          rate_valid;
    logic          rate_ovf;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    heart_rate_meter #(
        .WINDOW_TICKS(W),
        .CNT_W       (CW),
        .SYNC_STAGES (SS)
`ifdef HR_LOCKOUT_EN
        ,
        .LOCKOUT_CYC (LK)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .beat_in   (beat_in),
        .enable    (enable),
        .rate      (rate),
        .rate_valid(rate_valid),
        .rate_ovf  (rate_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // Model: an edge is a 0->1 in the sampled beat stream, seen SS posedges later.
    // Mode 0 idle, 1 waiting for the aligning tick, 2 inside a window, 3 report cycle.
    logic bh [SS+2];
    int   mode      = 0;
    int   ticks     = 0;
    int   beats     = 0;
    int   lock      = 0;
    int   exp_rate  = 0;
    int   exp_ovf   = 0;
    int   exp_valid = 0;
    int   exp_busy  = 0;

    initial for (int i = 0; i < SS + 2; i++) bh[i] = 1'b0;

    always @(posedge clk) begin
        bit raw;
        bit ev;
        for (int i = SS + 1; i > 0; i--) bh[i] = bh[i-1];
        bh[0] = beat_in;
        raw = bh[SS] && !bh[SS+1];
        ev  = raw;
`ifdef HR_LOCKOUT_EN
        if (rst) begin
            lock = 0;
        end else if (raw && lock == 0) begin
            lock = LK;
        end else begin
            ev = 1'b0;
            if (lock > 0) lock--;
        end
`endif
        exp_valid = 0;
        if (rst) begin
            mode = 0; exp_rate = 0; exp_ovf = 0; beats = 0;
        end else begin
            case (mode)
                0: if (enable) mode = 1;
                1: begin
                    if (!enable) mode = 0;
                    else if (tick) begin mode = 2; ticks = 0; beats = 0; end
                end
                2: begin
                    if (!enable) mode = 0;
                    else begin
                        if (ev) beats++;
                        if (tick) begin
                            ticks++;
                            if (ticks == W) begin
                                exp_rate  = (beats > MAXC) ? MAXC : beats;
                                exp_ovf   = (beats > MAXC) ? 1 : 0;
                                exp_valid = 1;
                                mode      = 3;
                            end
                        end
                    end
                end
                default: begin
                    if (enable) begin
                        mode = 2; ticks = 0; beats = ev ? 1 : 0;
                    end else begin
                        mode = 0;
                    end
                end
            endcase
        end
        exp_busy = (mode == 1 || mode == 2) ? 1 : 0;
    end

    int obs_cyc[$];
    int obs_rate[$];
    int obs_ovf[$];

    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("rate_valid", int'(rate_valid), exp_valid);
            check("rate", int'(rate), exp_rate);
            check("rate_ovf", int'(rate_ovf), exp_ovf);
            check("busy", int'(busy), exp_busy);
            if (rate_valid) begin
                obs_cyc.push_back(cyc);
                obs_rate.push_back(int'(rate));
                obs_ovf.push_back(int'(rate_ovf));
            end
        end
    end

    int s        = 0;
    bit rnd_tick = 1'b0;
    int tick_cd  = 0;

    task automatic step(input logic b);
        @(posedge clk);
        s++;
        #1;
        beat_in = b;
        if (rnd_tick) begin
            if (tick_cd == 0) begin
                tick    = 1'b1;
                tick_cd = int'($urandom_range(24, 4));
            end else begin
                tick = 1'b0;
                tick_cd--;
            end
        end else begin
            tick = (s % PERIOD == 0);
        end
    endtask

    task automatic idle_to(input int t);
        while (s < t) step(1'b0);
    endtask

    // Rising edge of beat_in driven at step r, held two cycles.
    task automatic beat_at(input int r);
        while (s < r - 1) step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b0);
    endtask

    int t0;
    int t1;
    int exp_c[$];
    int exp_r[$];
    int exp_o[$];
    int dens;

    initial begin
        repeat (3) step(1'b0);
        check("rst_rate", int'(rate), 0);
        check("rst_valid", int'(rate_valid), 0);
        check("rst_ovf", int'(rate_ovf), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;

        idle_to(60);
        check("no_strobe_disabled", obs_cyc.size(), 0);

        idle_to(65);
        enable = 1'b1;
        t0 = 80;
`ifndef HR_LOCKOUT_EN
        beat_at(t0 + 10); beat_at(t0 + 25); beat_at(t0 + 35);
        beat_at(t0 + 45); beat_at(t0 + 55);
        beat_at(t0 + 158);
        beat_at(t0 + 190); beat_at(t0 + 200);
        beat_at(t0 + 239);
        for (int i = 0; i < 20; i++) beat_at(t0 + 320 + 4 * i);
        beat_at(t0 + 410); beat_at(t0 + 430); beat_at(t0 + 450);
        beat_at(t0 + 490); beat_at(t0 + 500);
        idle_to(t0 + 520);
        enable = 1'b0;
        idle_to(t0 + 530);
        check("abort_hold_rate", int'(rate), 3);
        check("abort_busy", int'(busy), 0);
        enable = 1'b1;
        t1 = t0 + 540;
        beat_at(t1 + 10); beat_at(t1 + 30);
        idle_to(t1 + 90);
        exp_c = '{t0 + 81, t0 + 161, t0 + 241, t0 + 321, t0 + 401, t0 + 481, t1 + 81};
        exp_r = '{5, 1, 2, 1, 15, 3, 2};
        exp_o = '{0, 0, 0, 0, 1, 0, 0};
`else
        beat_at(t0 + 10); beat_at(t0 + 14); beat_at(t0 + 18);
        beat_at(t0 + 100); beat_at(t0 + 112); beat_at(t0 + 124);
        idle_to(t0 + 170);
        exp_c = '{t0 + 81, t0 + 161};
        exp_r = '{1, 3};
        exp_o = '{0, 0};
`endif
        check("strobe_count", obs_cyc.size(), exp_c.size());
        for (int i = 0; i < exp_c.size() && i < obs_cyc.size(); i++) begin
            check("win_cycle", obs_cyc[i], exp_c[i]);
            check("win_rate", obs_rate[i], exp_r[i]);
            check("win_ovf", obs_ovf[i], exp_o[i]);
        end

        tick_cd  = 10;
        rnd_tick = 1'b1;
        dens     = 4;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) dens = int'($urandom_range(12, 2));
            if ($urandom_range(299, 0) == 0) enable = ~enable;
            if (i == 2000) begin
                repeat (4) step(1'b0);
                rst = 1'b1;
                repeat (2) step(1'b0);
                rst = 1'b0;
            end
            step(($urandom_range(dens - 1, 0) == 0) ? 1'b1 : 1'b0);
        end
        repeat (3) step(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
